// File: rtl/preadd_mult_stage.sv
// preadd_mult_stage: D+/-B pre-adder feeding the B1 stage, A1/B1 operand registers and an 18x18 unsigned multiplier with optional M register
module preadd_mult_stage #(
  parameter int A1REG = 1,
  parameter int B1REG = 1,
  parameter int MREG = 1,
  parameter int OPMODEREG = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [7:0]  OPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEM,
  input  logic        CEOPMODE,
  output logic [17:0] BCOUT,
  output logic [35:0] M
);
  logic [1:0] opm_q, opm_eff;
  logic [17:0] a1_q, b1_q, a1, pre_sum, b1_in;
  logic [35:0] m_q, prod;
  logic unused_opm;
  assign unused_opm = ^{OPMODE[7], OPMODE[5], OPMODE[3:0]};
  // only the subtract (bit 6) and select (bit 4) mode bits are kept
  assign opm_eff = (OPMODEREG != 0) ? opm_q : {OPMODE[6], OPMODE[4]};
  assign pre_sum = opm_eff[1] ? D - B : D + B;
  assign b1_in = opm_eff[0] ? pre_sum : B;
  assign BCOUT = (B1REG != 0) ? b1_q : b1_in;
  assign a1 = (A1REG != 0) ? a1_q : A;
  assign prod = 36'(a1) * 36'(BCOUT);
  assign M = (MREG != 0) ? m_q : prod;
  always_ff @(posedge CLK) begin
    if (RST) begin
      opm_q <= '0;
      a1_q <= '0;
      b1_q <= '0;
      m_q <= '0;
    end else begin
      if (CEOPMODE) opm_q <= {OPMODE[6], OPMODE[4]};
      if (CEA) a1_q <= A;
      if (CEB) b1_q <= b1_in;
      if (CEM) m_q <= prod;
    end
  end
endmodule

// File: doc/preadd_mult_stage.md
PREADD_MULT_STAGE -- requirements
Module: preadd_mult_stage

Interface
REQ-001 Parameter A1REG, default 1: 1 = A1 pipeline register present, 0 = bypassed (combinational path).
REQ-002 Parameter B1REG, default 1: 1 = B1 pipeline register present, 0 = bypassed.
REQ-003 Parameter MREG, default 1: 1 = M product register present, 0 = bypassed.
REQ-004 Parameter OPMODEREG, default 1: 1 = OPMODE register present, 0 = bypassed.
REQ-005 CLK  input  1  single clock; all registers update on rising edge only.
REQ-006 RST  input  1  reset, synchronous, active-high; clears every internal register.
REQ-007 A  input  18  multiplier operand A, from the upstream A0 18-bit register/mux stage.
REQ-008 B  input  18  operand B, from the upstream B0 18-bit register/mux stage.
REQ-009 D  input  18  pre-adder operand D, from the upstream D 18-bit register/mux stage.
REQ-010 OPMODE  input  8  operation mode; only bit 6 (pre-adder subtract) and bit 4 (pre-adder select) are used here.
REQ-011 CEA  input  1  clock enable for the A1 register.
REQ-012 CEB  input  1  clock enable for the B1 register.
REQ-013 CEM  input  1  clock enable for the M register.
REQ-014 CEOPMODE  input  1  clock enable for the OPMODE register.
REQ-015 BCOUT  output  18  B1 stage output (cascade and multiplier operand).
REQ-016 M  output  36  unsigned product A1 x B1.

Function
REQ-017 opm_eff SHALL be the OPMODE register output when OPMODEREG=1, else OPMODE directly.
REQ-018 Pre-adder: opm_eff[6]=0 -> D+B; opm_eff[6]=1 -> D-B; 18-bit result, modulo 2^18, carry/borrow discarded.
REQ-019 B1 stage input SHALL be the pre-adder result when opm_eff[4]=1, else B.
REQ-020 BCOUT SHALL be the B1 register output when B1REG=1, else the B1 stage input combinationally.
REQ-021 A1 stage output SHALL be the A1 register output when A1REG=1, else A combinationally.
REQ-022 Multiplier: 18x18 unsigned, full 36-bit product, no truncation or saturation.
REQ-023 M SHALL be the M register output when MREG=1, else the product combinationally.
REQ-024 Each present register loads on a rising edge only when its CE is 1 and RST is 0; otherwise it holds.
REQ-025 Latency (all parameters 1): A/B/D -> BCOUT 1 cycle; A/B/D -> M 2 cycles; OPMODE takes effect on the pre-adder 1 cycle after it is sampled.
REQ-026 Each parameter set to 0 SHALL remove exactly one cycle from every path through that register.
REQ-027 CE deasserted on one stage SHALL NOT stall other stages; downstream stages keep sampling the held value.
REQ-028 Parameter values outside {0,1} are illegal; behaviour is undefined.

Reset
REQ-029 RST=1 at a rising edge SHALL clear the A1, B1, M and OPMODE registers to 0, with priority over every CE.
REQ-030 Register reset values: BCOUT=0, M=0, opm_eff=0 (add, B passthrough) for registered paths; bypassed paths follow their inputs during reset.
REQ-031 RST asserted mid-pipeline SHALL discard all in-flight data; the first valid M after release comes 2 cycles after new inputs are sampled.

Verification
REQ-032 All params 1, OPMODE=0x10 held, A=3, B=5, D=10, all CEs=1 -> BCOUT=15 after edge 1, M=45 after edge 2.
REQ-033 OPMODE=0x50 held, D=0, B=1, A=1 -> BCOUT=0x3FFFF (wrap) and M=0x3FFFF one cycle later.
REQ-034 OPMODE=0x00, A=B=0x3FFFF -> BCOUT=0x3FFFF, M=0xFFFF80001.
REQ-035 Steady state M=45, then CEM=0 while A changes to 7 -> M stays 45; CEM=1 -> M=105 on the next edge.
REQ-036 Pipeline full, RST=1 for one edge with all CEs=0 -> BCOUT=0 and M=0 after that edge.
REQ-037 All params 0, OPMODE=0x50, D=9, B=4, A=2 -> BCOUT=5 and M=10 in the same cycle, no clock edge needed.
